// File: rtl/gtx_rx_byte_gearbox_if.sv
// Word-in / byte-out stream bundle for the GTX RX byte gearbox.
// The master drives words and byte back-pressure; the slave returns the byte stream.
interface gtx_rx_byte_gearbox_if #(
  parameter int BYTES_PER_WORD = 2
);
  logic [8*BYTES_PER_WORD-1:0] din;
  logic [BYTES_PER_WORD-1:0]   din_k;
  logic                        din_valid;
  logic [7:0]                  dout;
  logic                        dout_k;
  logic                        dout_valid;
  logic                        dout_ready;

  modport master (
    output din, din_k, din_valid, dout_ready,
    input  dout, dout_k, dout_valid
  );

  modport slave (
    input  din, din_k, din_valid, dout_ready,
    output dout, dout_k, dout_valid
  );
endinterface

// File: rtl/gtx_rx_byte_gearbox.sv
// Splits GTX RX words into a byte stream: word FIFO, holding register and a
// registered valid/ready output stage, with optional comma alignment and dropping.
module gtx_rx_byte_gearbox #(
  parameter int         BYTES_PER_WORD = 2,
  parameter int         FIFO_DEPTH     = 8,
  parameter int         MSB_FIRST      = 1,
  parameter logic [7:0] COMMA_CHAR     = 8'hBC,
  parameter int         DROP_COMMA     = 0,
  parameter int         ALIGN_EN       = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  gtx_rx_byte_gearbox_if.slave          bus,
  input  logic                          relock,
  input  logic                          clr_ovf,
  output logic                          locked,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int N  = BYTES_PER_WORD;
  localparam int LW = $clog2(FIFO_DEPTH);
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int WW = 9 * N;

  localparam logic [IW-1:0] FIRST_IDX = (MSB_FIRST != 0) ? IW'(N - 1) : '0;
  localparam logic [IW-1:0] LAST_IDX  = (MSB_FIRST != 0) ? '0 : IW'(N - 1);
  localparam logic [IW-1:0] IDX_ONE   = 1;
  localparam logic [LW-1:0] PTR_ONE   = 1;
  localparam logic [LW:0]   LVL_ONE   = 1;
  localparam logic          LOCK_INIT = (ALIGN_EN == 0);

  logic [WW-1:0]    mem [FIFO_DEPTH];
  logic [LW-1:0]    wr_ptr;
  logic [LW-1:0]    rd_ptr;
  logic [LW:0]      level;
  logic [WW-1:0]    head;
  logic             fifo_full;
  logic             fifo_empty;

  logic [8*N-1:0]   hold_data;
  logic [N-1:0]     hold_k;
  logic [IW-1:0]    hold_idx;
  logic             hold_valid;

  logic             has_comma;
  logic [7:0]       cur_byte;
  logic             cur_k;
  logic             cur_drop;
  logic             accept;
  logic             adv;
  logic             hold_want;
  logic             pop;
  logic             push;
  logic             ovf_event;

  always_comb begin
    has_comma = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (bus.din_k[i] && (bus.din[8*i +: 8] == COMMA_CHAR)) begin
        has_comma = 1'b1;
      end
    end
  end

  always_comb begin
    cur_byte = '0;
    cur_k    = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (hold_idx == IW'(i)) begin
        cur_byte = hold_data[8*i +: 8];
        cur_k    = hold_k[i];
      end
    end
  end

  assign fifo_full  = (level == (LW+1)'(FIFO_DEPTH));
  assign fifo_empty = (level == '0);
  assign head       = mem[rd_ptr];
  assign fifo_level = level;

  // Holding reloads from the FIFO when idle or as its last byte leaves, so words run back to back.
  assign cur_drop  = (DROP_COMMA != 0) && cur_k && (cur_byte == COMMA_CHAR);
  assign accept    = bus.din_valid && !relock && (locked || has_comma);
  assign adv       = hold_valid && (!bus.dout_valid || bus.dout_ready);
  assign hold_want = !hold_valid || (adv && (hold_idx == LAST_IDX));
  assign pop       = hold_want && !fifo_empty && !relock;
  assign push      = accept && (!fifo_full || pop);
  assign ovf_event = accept && fifo_full && !pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (relock) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   level <= level + LVL_ONE;
        2'b01:   level <= level - LVL_ONE;
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {bus.din_k, bus.din};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_data  <= '0;
      hold_k     <= '0;
      hold_idx   <= FIRST_IDX;
      hold_valid <= 1'b0;
    end else if (relock) begin
      hold_idx   <= FIRST_IDX;
      hold_valid <= 1'b0;
    end else if (hold_want) begin
      if (pop) begin
        hold_data  <= head[8*N-1:0];
        hold_k     <= head[WW-1:8*N];
        hold_idx   <= FIRST_IDX;
        hold_valid <= 1'b1;
      end else begin
        hold_valid <= 1'b0;
      end
    end else if (adv) begin
      hold_idx <= (MSB_FIRST != 0) ? (hold_idx - IDX_ONE) : (hold_idx + IDX_ONE);
    end
  end

  // A dropped comma still consumes its slot, leaving a one-cycle bubble on the output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.dout       <= '0;
      bus.dout_k     <= 1'b0;
      bus.dout_valid <= 1'b0;
    end else if (relock) begin
      bus.dout_valid <= 1'b0;
    end else if (!bus.dout_valid || bus.dout_ready) begin
      if (hold_valid && !cur_drop) begin
        bus.dout       <= cur_byte;
        bus.dout_k     <= cur_k;
        bus.dout_valid <= 1'b1;
      end else begin
        bus.dout_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      locked   <= LOCK_INIT;
      overflow <= 1'b0;
    end else begin
      if (relock) begin
        locked <= LOCK_INIT;
      end else if (bus.din_valid && has_comma) begin
        locked <= 1'b1;
      end
      overflow <= ovf_event || (overflow && !clr_ovf);
    end
  end

endmodule

// File: tb/tb_gtx_rx_byte_gearbox.sv
// Self-checking bench for gtx_rx_byte_gearbox: a 2-byte aligned/MSB-first instance
// and a 4-byte unaligned/LSB-first comma-dropping instance.
module tb_gtx_rx_byte_gearbox;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       relock_a, clr_ovf_a, locked_a, overflow_a;
  logic [3:0] level_a;
  logic       relock_b, clr_ovf_b, locked_b, overflow_b;
  logic [3:0] level_b;

  gtx_rx_byte_gearbox_if #(.BYTES_PER_WORD(2)) bus_a ();
  gtx_rx_byte_gearbox_if #(.BYTES_PER_WORD(4)) bus_b ();

  gtx_rx_byte_gearbox #(
    .BYTES_PER_WORD(2), .FIFO_DEPTH(8), .MSB_FIRST(1),
    .COMMA_CHAR(8'hBC), .DROP_COMMA(0), .ALIGN_EN(1)
  ) u_a (
    .clk(clk), .rst_n(rst_n), .bus(bus_a), .relock(relock_a), .clr_ovf(clr_ovf_a),
    .locked(locked_a), .overflow(overflow_a), .fifo_level(level_a)
  );

  gtx_rx_byte_gearbox #(
    .BYTES_PER_WORD(4), .FIFO_DEPTH(8), .MSB_FIRST(0),
    .COMMA_CHAR(8'hBC), .DROP_COMMA(1), .ALIGN_EN(0)
  ) u_b (
    .clk(clk), .rst_n(rst_n), .bus(bus_b), .relock(relock_b), .clr_ovf(clr_ovf_b),
    .locked(locked_b), .overflow(overflow_b), .fifo_level(level_b)
  );

  typedef struct {
    bit          sel;
    logic [31:0] din;
    logic [3:0]  k;
    logic        valid;
    logic        ready;
    logic        exp_valid;
    logic [7:0]  exp_dout;
    logic        exp_k;
    logic        exp_locked;
    logic [3:0]  exp_level;
  } vec_t;

  vec_t       vecs[$];
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  int         vectors = 0;
  int         miscompares = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: actual %0h required %0h", name, actual, expected);
    end
  endtask

  function automatic vec_t mk(bit sel, logic [31:0] din, logic [3:0] k, logic valid, logic ready,
                              logic ev, logic [7:0] ed, logic ek, logic el, logic [3:0] elev);
    vec_t v;
    v.sel = sel; v.din = din; v.k = k; v.valid = valid; v.ready = ready;
    v.exp_valid = ev; v.exp_dout = ed; v.exp_k = ek; v.exp_locked = el; v.exp_level = elev;
    return v;
  endfunction

  task automatic apply_stimulus(input vec_t v);
    if (v.sel == 1'b0) begin
      bus_a.din        = v.din[15:0];
      bus_a.din_k      = v.k[1:0];
      bus_a.din_valid  = v.valid;
      bus_a.dout_ready = v.ready;
      bus_b.din_valid  = 1'b0;
    end else begin
      bus_b.din        = v.din;
      bus_b.din_k      = v.k;
      bus_b.din_valid  = v.valid;
      bus_b.dout_ready = v.ready;
      bus_a.din_valid  = 1'b0;
    end
  endtask

  initial begin
    logic       push_now;
    logic       stall;
    logic [7:0] prev_dout;
    int         next_word;

    rst_n = 1'b0;
    relock_a = 1'b0; clr_ovf_a = 1'b0; relock_b = 1'b0; clr_ovf_b = 1'b0;
    bus_a.din = '0; bus_a.din_k = '0; bus_a.din_valid = 1'b0; bus_a.dout_ready = 1'b1;
    bus_b.din = '0; bus_b.din_k = '0; bus_b.din_valid = 1'b0; bus_b.dout_ready = 1'b1;
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    check_output("reset dout_valid a", 32'(bus_a.dout_valid), 0);
    check_output("reset dout a", 32'(bus_a.dout), 0);
    check_output("reset level a", 32'(level_a), 0);
    check_output("reset locked a", 32'(locked_a), 0);
    check_output("reset locked b", 32'(locked_b), 1);
    check_output("reset overflow b", 32'(overflow_b), 0);

    // Aligned MSB-first: pre-comma word discarded, comma word locks and streams.
    vecs.push_back(mk(0, 32'h1234, 4'b00, 1, 1, 0, 8'h00, 0, 0, 0));
    vecs.push_back(mk(0, 32'h0,    4'b00, 0, 1, 0, 8'h00, 0, 0, 0));
    vecs.push_back(mk(0, 32'hBC50, 4'b10, 1, 1, 0, 8'h00, 0, 1, 1));
    vecs.push_back(mk(0, 32'h0,    4'b00, 0, 1, 0, 8'h00, 0, 1, 0));
    vecs.push_back(mk(0, 32'hA1A2, 4'b00, 1, 1, 1, 8'hBC, 1, 1, 1));
    vecs.push_back(mk(0, 32'h0,    4'b00, 0, 1, 1, 8'h50, 0, 1, 0));
    vecs.push_back(mk(0, 32'h0,    4'b00, 0, 1, 1, 8'hA1, 0, 1, 0));
    vecs.push_back(mk(0, 32'h0,    4'b00, 0, 1, 1, 8'hA2, 0, 1, 0));
    vecs.push_back(mk(0, 32'h0,    4'b00, 0, 1, 0, 8'h00, 0, 1, 0));
    // Unaligned LSB-first 4-byte words, then a word whose comma is dropped.
    vecs.push_back(mk(1, 32'h44332211, 4'b0000, 1, 1, 0, 8'h00, 0, 1, 1));
    vecs.push_back(mk(1, 32'h0,        4'b0000, 0, 1, 0, 8'h00, 0, 1, 0));
    vecs.push_back(mk(1, 32'h0,        4'b0000, 0, 1, 1, 8'h11, 0, 1, 0));
    vecs.push_back(mk(1, 32'h0,        4'b0000, 0, 1, 1, 8'h22, 0, 1, 0));
    vecs.push_back(mk(1, 32'h0,        4'b0000, 0, 1, 1, 8'h33, 0, 1, 0));
    vecs.push_back(mk(1, 32'h0,        4'b0000, 0, 1, 1, 8'h44, 0, 1, 0));
    vecs.push_back(mk(1, 32'h4433BC11, 4'b0010, 1, 1, 0, 8'h00, 0, 1, 1));
    vecs.push_back(mk(1, 32'h0,        4'b0000, 0, 1, 0, 8'h00, 0, 1, 0));
    vecs.push_back(mk(1, 32'h0,        4'b0000, 0, 1, 1, 8'h11, 0, 1, 0));
    vecs.push_back(mk(1, 32'h0,        4'b0000, 0, 1, 0, 8'h00, 0, 1, 0));
    vecs.push_back(mk(1, 32'h0,        4'b0000, 0, 1, 1, 8'h33, 0, 1, 0));
    vecs.push_back(mk(1, 32'h0,        4'b0000, 0, 1, 1, 8'h44, 0, 1, 0));
    vecs.push_back(mk(1, 32'h0,        4'b0000, 0, 1, 0, 8'h00, 0, 1, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      apply_stimulus(vecs[i]);
      tick();
      if (vecs[i].sel == 1'b0) begin
        check_output($sformatf("row%0d valid", i), 32'(bus_a.dout_valid), 32'(vecs[i].exp_valid));
        if (vecs[i].exp_valid) begin
          check_output($sformatf("row%0d dout", i), 32'(bus_a.dout), 32'(vecs[i].exp_dout));
          check_output($sformatf("row%0d dout_k", i), 32'(bus_a.dout_k), 32'(vecs[i].exp_k));
        end
        check_output($sformatf("row%0d locked", i), 32'(locked_a), 32'(vecs[i].exp_locked));
        check_output($sformatf("row%0d level", i), 32'(level_a), 32'(vecs[i].exp_level));
      end else begin
        check_output($sformatf("row%0d valid", i), 32'(bus_b.dout_valid), 32'(vecs[i].exp_valid));
        if (vecs[i].exp_valid) begin
          check_output($sformatf("row%0d dout", i), 32'(bus_b.dout), 32'(vecs[i].exp_dout));
          check_output($sformatf("row%0d dout_k", i), 32'(bus_b.dout_k), 32'(vecs[i].exp_k));
        end
        check_output($sformatf("row%0d locked", i), 32'(locked_b), 32'(vecs[i].exp_locked));
        check_output($sformatf("row%0d level", i), 32'(level_b), 32'(vecs[i].exp_level));
      end
    end
    bus_b.din_valid = 1'b0;

    // Overflow: 8 words fill the FIFO, one sits in holding, the tenth is dropped.
    bus_a.dout_ready = 1'b0;
    for (int w = 0; w < 10; w++) begin
      bus_a.din       = {8'(8'h10 + w), 8'(8'h80 + w)};
      bus_a.din_k     = 2'b00;
      bus_a.din_valid = 1'b1;
      tick();
    end
    bus_a.din_valid = 1'b0;
    check_output("full level", 32'(level_a), 8);
    check_output("overflow set", 32'(overflow_a), 1);
    got_q.delete();
    bus_a.dout_ready = 1'b1;
    for (int c = 0; c < 40; c++) begin
      if (bus_a.dout_valid) got_q.push_back(bus_a.dout);
      tick();
    end
    check_output("drain count", got_q.size(), 18);
    for (int w = 0; w < 9; w++) begin
      if (2*w+1 < got_q.size()) begin
        check_output($sformatf("drain w%0d hi", w), 32'(got_q[2*w]), 32'(8'(8'h10 + w)));
        check_output($sformatf("drain w%0d lo", w), 32'(got_q[2*w+1]), 32'(8'(8'h80 + w)));
      end
    end
    check_output("overflow sticky", 32'(overflow_a), 1);
    clr_ovf_a = 1'b1;
    tick();
    clr_ovf_a = 1'b0;
    check_output("overflow cleared", 32'(overflow_a), 0);

    // Random back-pressure over a 0..255 byte ramp against a byte-queue model.
    exp_q.delete();
    next_word = 0;
    for (int cyc = 0; cyc < 4000 && !(next_word == 128 && exp_q.size() == 0); cyc++) begin
      push_now = (next_word < 128) && (exp_q.size() < 12) && ($urandom_range(0, 1) == 1);
      if (push_now) begin
        bus_a.din       = {8'(2*next_word), 8'(2*next_word + 1)};
        bus_a.din_k     = 2'b00;
        bus_a.din_valid = 1'b1;
        exp_q.push_back(8'(2*next_word));
        exp_q.push_back(8'(2*next_word + 1));
        next_word++;
      end else begin
        bus_a.din_valid = 1'b0;
      end
      bus_a.dout_ready = ($urandom_range(0, 3) != 0);
      if (bus_a.dout_valid && bus_a.dout_ready) begin
        if (exp_q.size() == 0) begin
          check_output("ramp unexpected byte", 32'(bus_a.dout), 32'h1FF);
        end else begin
          check_output("ramp byte", 32'(bus_a.dout), 32'(exp_q.pop_front()));
        end
      end
      stall = bus_a.dout_valid && !bus_a.dout_ready;
      prev_dout = bus_a.dout;
      tick();
      if (stall) begin
        check_output("stall valid", 32'(bus_a.dout_valid), 1);
        check_output("stall dout", 32'(bus_a.dout), 32'(prev_dout));
      end
    end
    bus_a.din_valid = 1'b0;
    bus_a.dout_ready = 1'b1;
    check_output("ramp complete", 32'(next_word == 128 && exp_q.size() == 0), 1);
    check_output("ramp no overflow", 32'(overflow_a), 0);

    // Reset in the middle of a word clears everything immediately.
    bus_a.din = 16'h1122; bus_a.din_k = 2'b00; bus_a.din_valid = 1'b1;
    tick();
    bus_a.din_valid = 1'b0;
    tick();
    tick();
    check_output("pre-reset byte", 32'(bus_a.dout), 32'h11);
    #2;
    rst_n = 1'b0;
    #1;
    check_output("async reset valid", 32'(bus_a.dout_valid), 0);
    check_output("async reset level", 32'(level_a), 0);
    check_output("async reset locked", 32'(locked_a), 0);
    rst_n = 1'b1;
    tick();

    // RELOCK mid-word; a comma presented with RELOCK must not relock.
    bus_a.din = 16'hBC77; bus_a.din_k = 2'b10; bus_a.din_valid = 1'b1;
    tick();
    check_output("relock pre locked", 32'(locked_a), 1);
    bus_a.din = 16'h3344; bus_a.din_k = 2'b00;
    tick();
    bus_a.din_valid = 1'b0;
    tick();
    check_output("relock pre byte", 32'(bus_a.dout), 32'hBC);
    relock_a = 1'b1;
    bus_a.din = 16'hBC88; bus_a.din_k = 2'b10; bus_a.din_valid = 1'b1;
    tick();
    relock_a = 1'b0;
    bus_a.din_valid = 1'b0;
    check_output("relock valid", 32'(bus_a.dout_valid), 0);
    check_output("relock level", 32'(level_a), 0);
    check_output("relock locked", 32'(locked_a), 0);
    tick();
    check_output("relock idle valid", 32'(bus_a.dout_valid), 0);
    bus_a.din = 16'hBC99; bus_a.din_k = 2'b10; bus_a.din_valid = 1'b1;
    tick();
    bus_a.din_valid = 1'b0;
    check_output("relocked", 32'(locked_a), 1);
    tick();
    tick();
    check_output("relock first valid", 32'(bus_a.dout_valid), 1);
    check_output("relock first dout", 32'(bus_a.dout), 32'hBC);
    check_output("relock first k", 32'(bus_a.dout_k), 1);
    tick();
    check_output("relock second dout", 32'(bus_a.dout), 32'h99);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
